// File: rtl/fsk_pkg.sv
// ----------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the FSK receiver chain.
//   state_t     : period-meter FSM encoding (IDLE, ACQ, TRACK)
//   CNT_W       : width of the half-period interval counter
//   ASTAVEL_OFS : astavel spends C+ASTAVEL_OFS cycles per half-period, so the
//                 published word is the measured average minus this offset
// ----------------------------------------------------------------------------
package fsk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int CNT_W       = 21;
    localparam int ASTAVEL_OFS = 2;

endpackage : fsk_pkg

// File: rtl/sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous pin, followed by a both-edge
// detector (rising and falling transitions both produce a pulse).
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (synchronizer flops clear to 0)
//   d      : asynchronous input pin
//   d_edge : one-cycle pulse when the synchronized level changes
//            ('edge' itself is a reserved word, hence the name)
// A pin transition captured at clock k raises d_edge during the cycle after
// clock k+1, so it is acted upon at clock k+2.
// ----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic d_edge
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value of its neighbour; with = the chain would collapse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign d_edge = r_s2 ^ r_prev;

endmodule : sync_edge

// File: rtl/fsk_period_meter.sv
// ----------------------------------------------------------------------------
// fsk_period_meter
// Measures the half-period of the squared FSK line signal, averages AVG_N
// accepted intervals and publishes the astavel half-period word plus a
// mark/space decision.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   sig_in  : asynchronous comparator output (FSK square wave)
//   C       : half-period word for astavel, average minus 2, zero-extended
//   c_valid : one-cycle pulse when C / bit_out update
//   bit_out : 1 (mark) when average < THRESH, else 0 (space)
//   locked  : high once a full average has been published since the last
//             timeout or reset
// ----------------------------------------------------------------------------
module fsk_period_meter
    import fsk_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int MIN_HALF = 8,
    parameter int MAX_HALF = 1048576,
    parameter int THRESH   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic [31:0] C,
    output logic        c_valid,
    output logic        bit_out,
    output logic        locked
);

    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam int N_W   = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HALF);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_OFS = CNT_W'(ASTAVEL_OFS);
    localparam logic [N_W-1:0]   N_LAST  = N_W'(AVG_N - 1);

    // ---------------- registers ----------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   r_sum;
    logic [N_W-1:0]     r_n;
    logic [31:0]        r_c;
    logic               r_c_valid;
    logic               r_bit;
    logic               r_locked;

    // ---------------- combinational ----------------
    logic               w_edge;
    logic               w_timeout;
    logic               w_accept;
    logic [SUM_W-1:0]   w_acc;
    logic [CNT_W-1:0]   w_avg;
    state_t             w_state_next;
    logic [SUM_W-1:0]   w_sum_next;
    logic [N_W-1:0]     w_n_next;
    logic               w_publish;

    sync_edge u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sig_in),
        .d_edge (w_edge)
    );

    // The counter sits saturated at MAX_HALF while IDLE, so the timeout only
    // matters while a measurement is in progress; otherwise IDLE could never
    // accept its first edge. A timeout beats a coincident edge.
    assign w_timeout = (r_state != IDLE) && (r_cnt == CNT_MAX);
    assign w_accept  = w_edge && (r_cnt >= CNT_MIN) && !w_timeout;

    // Sum including the interval ending now; the average is taken from it
    // directly so the publish cycle sees all AVG_N intervals.
    assign w_acc = r_sum + SUM_W'(r_cnt);
    assign w_avg = CNT_W'(w_acc >> AVG_LOG2);

    // ---------------- interval counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_next;
            r_sum   <= w_sum_next;
            r_n     <= w_n_next;
        end
    end

    // ---------------- FSM: next state / accumulation ----------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_sum_next   = r_sum;
        w_n_next     = r_n;
        w_publish    = 1'b0;
        case (r_state)
            IDLE: begin
                // First edge only establishes the reference point.
                if (w_accept) begin
                    w_state_next = ACQ;
                    w_sum_next   = '0;
                    w_n_next     = '0;
                end
            end
            ACQ, TRACK: begin
                if (w_timeout) begin
                    w_state_next = IDLE;
                    w_sum_next   = '0;
                    w_n_next     = '0;
                end else if (w_accept) begin
                    if (r_n == N_LAST) begin
                        w_publish    = 1'b1;
                        w_state_next = TRACK;
                        w_sum_next   = '0;
                        w_n_next     = '0;
                    end else begin
                        w_sum_next = w_acc;
                        w_n_next   = r_n + N_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_sum_next   = '0;
                w_n_next     = '0;
            end
        endcase
    end

    // ---------------- output registers ----------------
    // C and bit_out hold through a timeout; only locked drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c       <= '0;
            r_c_valid <= 1'b0;
            r_bit     <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_c_valid <= w_publish;
            if (w_publish) begin
                r_c      <= 32'(w_avg - CNT_OFS);
                r_bit    <= (w_avg < CNT_THR);
                r_locked <= 1'b1;
            end else if (w_timeout) begin
                r_locked <= 1'b0;
            end
        end
    end

    assign C       = r_c;
    assign c_valid = r_c_valid;
    assign bit_out = r_bit;
    assign locked  = r_locked;

endmodule : fsk_period_meter
